// File: rtl/axi_ad9361_rx_pack.sv
// axi_ad9361_rx_pack: decimates per-channel ADC samples and packs enabled channels into 64-bit DMA words
module axi_ad9361_rx_pack #(
    parameter int MODE_1R1T = 0
) (
    input  logic        adc_clk,
    input  logic        adc_rstn,
    input  logic        adc_sync,
    input  logic [15:0] adc_datarate,
    input  logic        adc_r1_mode,
    input  logic        adc_valid,
    input  logic        adc_enable_i0,
    input  logic        adc_enable_q0,
    input  logic        adc_enable_i1,
    input  logic        adc_enable_q1,
    input  logic [15:0] adc_data_i0,
    input  logic [15:0] adc_data_q0,
    input  logic [15:0] adc_data_i1,
    input  logic [15:0] adc_data_q1,
    output logic        pack_valid,
    output logic [63:0] pack_data,
    output logic        pack_sync
);
    logic [15:0]       cnt;
    logic [3:0]        mask;
    logic [3:0]        mask_nxt;
    logic [3:0]        fill;
    logic [3:0]        total;
    logic [127:0]      stage;
    logic [127:0]      merged;
    logic              sync_pending;
    logic              accept;
    logic              emit;
    logic [2:0]        n;
    logic [63:0]       beat;
    logic [3:0][15:0]  smp;

    assign smp      = {adc_data_q1, adc_data_i1, adc_data_q0, adc_data_i0};
    assign mask_nxt = {adc_enable_q1, adc_enable_i1, adc_enable_q0, adc_enable_i0} &
                      ((MODE_1R1T != 0 || adc_r1_mode) ? 4'b0011 : 4'b1111);
    assign accept   = adc_valid && cnt == 16'd0 && !adc_sync;
    assign total    = fill + {1'b0, n};
    assign emit     = accept && total >= 4'd4;
    // fill never exceeds 3 after an update, so the appended beat always fits below bit 112
    assign merged   = stage | ({64'd0, beat} << {fill, 4'b0000});

    always_comb begin
        beat = '0;
        n = '0;
        for (int c = 0; c < 4; c++) begin
            if (mask[c]) begin
                beat[{n[1:0], 4'b0000} +: 16] = smp[c];
                n = n + 3'd1;
            end
        end
    end

    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            cnt          <= '0;
            mask         <= '0;
            fill         <= '0;
            stage        <= '0;
            sync_pending <= 1'b0;
            pack_valid   <= 1'b0;
            pack_data    <= '0;
            pack_sync    <= 1'b0;
        end else begin
            cnt        <= (adc_sync || cnt == 16'd0) ? adc_datarate : cnt - 16'd1;
            pack_valid <= emit;
            pack_sync  <= emit && sync_pending;
            if (emit)
                pack_data <= merged[63:0];
            if (adc_sync) begin
                mask         <= mask_nxt;
                fill         <= '0;
                stage        <= '0;
                sync_pending <= 1'b1;
            end else if (accept) begin
                fill  <= emit ? total - 4'd4 : total;
                stage <= emit ? {64'd0, merged[127:64]} : merged;
                if (emit)
                    sync_pending <= 1'b0;
            end
        end
    end
endmodule
